// File: rtl/preamble_detector.sv
// preamble_detector
// Front-end framer for the RFID backscatter receive path. A 1-bit sample
// stream is correlated against BANKS time-scaled copies of a fixed preamble
// template. On detection the best-matching bank is reported. Later samples
// are forwarded as payload until a run of LENGTH/2 zeros ends the frame.
// The detector then waits for the correlation to fall away before it
// searches again.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset
//   in_dat / in_vld     input sample and its qualifier (no backpressure)
//   out_dat / out_vld   forwarded payload sample, one-cycle strobe
//   frequency_bank      bank index of the last detection (reset: centre bank)
//   preamble_detected   one-cycle pulse on detection
//   postamble_detected  one-cycle pulse on end-of-frame
//   best_score          (only with PREAMBLE_DETECTOR_SCORE_EN) best bank score
//                       of the last accepted sample
//
// Optional feature macro: PREAMBLE_DETECTOR_SCORE_EN
module preamble_detector #(
  parameter int LENGTH       = 80,
  parameter int BANKS        = 9,
  parameter int HI_THRESHOLD = 75,
  parameter int LO_THRESHOLD = 70,
  parameter int SCALING_BITS = 5,
  parameter logic [LENGTH-1:0] PREAMBLE =
    80'b1111111111000011110000000011111000000000000011111111
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_dat,
  input  logic                       in_vld,
  output logic                       out_dat,
  output logic                       out_vld,
  output logic [$clog2(BANKS)-1:0]   frequency_bank,
  output logic                       preamble_detected,
  output logic                       postamble_detected
`ifdef PREAMBLE_DETECTOR_SCORE_EN
  ,
  output logic [$clog2(LENGTH+1)-1:0] best_score
`endif
);

  localparam int SW     = $clog2(LENGTH + 1);
  localparam int BW     = $clog2(BANKS);
  localparam int ZW     = $clog2(LENGTH / 2 + 1);
  localparam int CENTRE = (BANKS - 1) / 2;
  localparam int UNITY  = 2 ** SCALING_BITS;

  localparam logic [SW-1:0] HI_T     = SW'(HI_THRESHOLD);
  localparam logic [SW-1:0] LO_T     = SW'(LO_THRESHOLD);
  localparam logic [ZW-1:0] ZRUN_END = ZW'(LENGTH / 2);
  localparam logic [BW-1:0] BANK_RST = BW'(CENTRE);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_DATA,
    S_REARM
  } state_t;

  // Bank b's template is the preamble resampled at rate
  // (UNITY + b - CENTRE) / UNITY. Positions that map past the end of the
  // preamble read as zero.
  function automatic logic [LENGTH-1:0] make_template(input int b);
    logic [LENGTH-1:0] t;
    int j;
    t = '0;
    for (int i = 0; i < LENGTH; i++) begin
      j = (i * UNITY) / (UNITY + b - CENTRE);
      if (j < LENGTH) t[i] = PREAMBLE[j];
    end
    return t;
  endfunction

  function automatic logic [SW-1:0] popcount(input logic [LENGTH-1:0] v);
    logic [SW-1:0] n;
    n = '0;
    for (int i = 0; i < LENGTH; i++) n = n + SW'(v[i]);
    return n;
  endfunction

  // Only the LENGTH-1 newest samples are stored. The window that is scored
  // always includes the current in_dat, so the oldest stored bit would
  // never be read.
  logic [LENGTH-2:0] window_q, window_d;
  logic [LENGTH-1:0] shift_win;
  state_t            state_q, state_d;
  logic [ZW-1:0]     zrun_q, zrun_d, zrun_inc;
  logic              out_dat_q, out_dat_d;
  logic              out_vld_q, out_vld_d;
  logic              pre_q, pre_d;
  logic              post_q, post_d;
  logic [BW-1:0]     bank_q, bank_d;

  logic [SW-1:0]     score [BANKS];
  logic [SW-1:0]     best_score_c;
  logic [BW-1:0]     best_bank_c;

  assign shift_win = {window_q, in_dat};

  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    localparam logic [LENGTH-1:0] TMPL = make_template(gi);
    assign score[gi] = popcount(~(shift_win ^ TMPL));
  end

  // A bank replaces the running best only on a strictly higher score.
  // On a tie the lowest index is kept.
  always_comb begin
    best_score_c = score[0];
    best_bank_c  = '0;
    for (int b = 1; b < BANKS; b++) begin
      if (score[b] > best_score_c) begin
        best_score_c = score[b];
        best_bank_c  = BW'(b);
      end
    end
  end

  assign zrun_inc = zrun_q + ZW'(1);

  always_comb begin
    window_d  = window_q;
    state_d   = state_q;
    zrun_d    = zrun_q;
    out_dat_d = out_dat_q;
    out_vld_d = 1'b0;
    pre_d     = 1'b0;
    post_d    = 1'b0;
    bank_d    = bank_q;
    if (in_vld) begin
      window_d = shift_win[LENGTH-2:0];
      case (state_q)
        S_SEARCH: begin
          // The sample that completes the detection is not forwarded.
          if (best_score_c >= HI_T) begin
            pre_d   = 1'b1;
            bank_d  = best_bank_c;
            zrun_d  = '0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          out_dat_d = in_dat;
          out_vld_d = 1'b1;
          if (in_dat) begin
            zrun_d = '0;
          end else begin
            zrun_d = zrun_inc;
            if (zrun_inc == ZRUN_END) begin
              post_d  = 1'b1;
              state_d = S_REARM;
            end
          end
        end
        S_REARM: begin
          // Hysteresis: the tail of the preamble just received would
          // otherwise trigger again.
          if (best_score_c < LO_T) state_d = S_SEARCH;
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q  <= '0;
      state_q   <= S_SEARCH;
      zrun_q    <= '0;
      out_dat_q <= 1'b0;
      out_vld_q <= 1'b0;
      pre_q     <= 1'b0;
      post_q    <= 1'b0;
      bank_q    <= BANK_RST;
    end else begin
      window_q  <= window_d;
      state_q   <= state_d;
      zrun_q    <= zrun_d;
      out_dat_q <= out_dat_d;
      out_vld_q <= out_vld_d;
      pre_q     <= pre_d;
      post_q    <= post_d;
      bank_q    <= bank_d;
    end
  end

  assign out_dat            = out_dat_q;
  assign out_vld            = out_vld_q;
  assign preamble_detected  = pre_q;
  assign postamble_detected = post_q;
  assign frequency_bank     = bank_q;

`ifdef PREAMBLE_DETECTOR_SCORE_EN
  logic [SW-1:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (in_vld) score_d = best_score_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) score_q <= '0;
    else     score_q <= score_d;
  end

  assign best_score = score_q;
`endif

endmodule

// File: tb/tb_preamble_detector.sv
// Directed testbench for preamble_detector (default parameters).
// Per-sample expectations come from a small behavioural model of the
// correlator. Frame-level expectations are hand-computed constants: pulse
// counts, forwarded payload bits, the postamble position, and reset values.
module tb_preamble_detector;

  logic       clk;
  logic       rst;
  logic       in_dat;
  logic       in_vld;
  logic       out_dat;
  logic       out_vld;
  logic [3:0] frequency_bank;
  logic       preamble_detected;
  logic       postamble_detected;
`ifdef PREAMBLE_DETECTOR_SCORE_EN
  logic [6:0] best_score;
`endif

  preamble_detector dut (
    .clk                (clk),
    .rst                (rst),
    .in_dat             (in_dat),
    .in_vld             (in_vld),
    .out_dat            (out_dat),
    .out_vld            (out_vld),
    .frequency_bank     (frequency_bank),
    .preamble_detected  (preamble_detected),
    .postamble_detected (postamble_detected)
`ifdef PREAMBLE_DETECTOR_SCORE_EN
    ,
    .best_score         (best_score)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [79:0] PRE_CONST =
    80'b1111111111000011110000000011111000000000000011111111;

  int total;
  int bad;

  // Model state.
  logic [79:0] pre_v;
  logic [79:0] tmpl [9];
  logic [79:0] m_win;
  int          m_state;
  int          m_zrun;
  logic        e_dat;
  logic        e_vld;
  logic        e_pre;
  logic        e_post;
  int          e_bank;
  int          e_score;

  // Observed-stream bookkeeping.
  int   pre_cnt;
  int   post_cnt;
  int   vld_cnt;
  int   zrun_obs;
  logic fwd_q [$];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic build_templates();
    int j;
    pre_v = PRE_CONST;
    for (int b = 0; b < 9; b++) begin
      tmpl[b] = '0;
      for (int i = 0; i < 80; i++) begin
        j = (i * 32) / (28 + b);
        if (j < 80) tmpl[b][i] = pre_v[j];
      end
    end
  endtask

  task automatic model_reset();
    m_win   = '0;
    m_state = 0;
    m_zrun  = 0;
    e_dat   = 1'b0;
    e_vld   = 1'b0;
    e_pre   = 1'b0;
    e_post  = 1'b0;
    e_bank  = 4;
    e_score = 0;
  endtask

  // States: 0 search, 1 data, 2 rearm.
  task automatic model_step(input logic d, input logic v);
    logic [79:0] nw;
    int sc;
    int best;
    int bb;
    e_vld  = 1'b0;
    e_pre  = 1'b0;
    e_post = 1'b0;
    if (v) begin
      nw   = {m_win[78:0], d};
      best = -1;
      bb   = 0;
      for (int b = 0; b < 9; b++) begin
        sc = 0;
        for (int i = 0; i < 80; i++) if (nw[i] == tmpl[b][i]) sc++;
        if (sc > best) begin
          best = sc;
          bb   = b;
        end
      end
      e_score = best;
      case (m_state)
        0: if (best >= 75) begin
             e_pre   = 1'b1;
             e_bank  = bb;
             m_zrun  = 0;
             m_state = 1;
           end
        1: begin
             e_vld = 1'b1;
             e_dat = d;
             if (d) m_zrun = 0;
             else begin
               m_zrun++;
               if (m_zrun == 40) begin
                 e_post  = 1'b1;
                 m_state = 2;
               end
             end
           end
        default: if (best < 70) m_state = 0;
      endcase
      m_win = nw;
    end
  endtask

  task automatic step(input logic d, input logic v);
    in_dat = d;
    in_vld = v;
    @(posedge clk);
    model_step(d, v);
    @(negedge clk);
    check("out_vld", int'(out_vld), int'(e_vld));
    check("preamble_detected", int'(preamble_detected), int'(e_pre));
    check("postamble_detected", int'(postamble_detected), int'(e_post));
    check("frequency_bank", int'(frequency_bank), e_bank);
    if (e_vld) check("out_dat", int'(out_dat), int'(e_dat));
`ifdef PREAMBLE_DETECTOR_SCORE_EN
    check("best_score", int'(best_score), e_score);
`endif
    if (preamble_detected) begin
      pre_cnt++;
      zrun_obs = 0;
      fwd_q.delete();
    end
    if (out_vld) begin
      vld_cnt++;
      fwd_q.push_back(out_dat);
      if (out_dat) zrun_obs = 0;
      else zrun_obs++;
    end
    if (postamble_detected) begin
      check("post_on_zero40", zrun_obs, 40);
      check("post_with_vld_zero", int'({out_vld, out_dat}), 2);
    end
  endtask

  // Accepted sample, preceded by a random number of idle cycles.
  task automatic send(input logic d);
    while ($urandom_range(0, 3) == 0) step(1'($urandom_range(0, 1)), 1'b0);
    step(d, 1'b1);
  endtask

  task automatic send_junk(input int n);
    repeat (n) send(1'($urandom_range(0, 1)));
  endtask

  // Nominal or 33/32-stretched preamble. The last nerr transmitted samples
  // are inverted. Those positions carry template ones in every bank, so each
  // bank loses exactly nerr matches on the completed window.
  task automatic send_preamble(input int stretch, input int nerr);
    int   top;
    int   j;
    logic b;
    top = (stretch != 0) ? 82 : 79;
    for (int i = top; i >= 0; i--) begin
      j = (stretch != 0) ? (i * 32) / 33 : i;
      b = (j < 80) ? pre_v[j] : 1'b0;
      if (i < nerr) b = ~b;
      send(b);
    end
  endtask

  // An adjacent bank can cross the threshold one sample before the
  // template completes, so the detecting bank is left to the per-sample
  // model. Framing and payload are fixed regardless of that.
  task automatic run_frame(input string tag, input int stretch, input int nerr,
                           input logic [4:0] data);
    int p0;
    int q0;
    int n;
    logic [4:0] got;
    send_junk(30);
    p0 = pre_cnt;
    q0 = post_cnt;
    send_preamble(stretch, nerr);
    for (int k = 4; k >= 0; k--) send(data[k]);
    repeat (41) send(1'b0);
    check({tag, "_pre_pulses"}, pre_cnt - p0, 1);
    check({tag, "_post_pulses"}, post_cnt - q0, 1);
    n   = fwd_q.size();
    got = '0;
    if (n >= 45) for (int k = 0; k < 5; k++) got[4 - k] = fwd_q[n - 45 + k];
    check({tag, "_payload"}, int'(got), int'(data));
    $display("frame %s: bank=%0d forwarded=%0d payload=%b", tag,
             frequency_bank, n, got);
  endtask

  always @(negedge clk) if (postamble_detected) post_cnt++;

  initial begin
    int p0;
    total    = 0;
    bad      = 0;
    pre_cnt  = 0;
    post_cnt = 0;
    vld_cnt  = 0;
    zrun_obs = 0;
    rst      = 1'b1;
    in_dat   = 1'b0;
    in_vld   = 1'b0;
    build_templates();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_out_dat", int'(out_dat), 0);
    check("rst_pre", int'(preamble_detected), 0);
    check("rst_post", int'(postamble_detected), 0);
    check("rst_bank", int'(frequency_bank), 4);
    rst = 1'b0;
    $display("reset: bank=%0d", frequency_bank);

    // Random junk with random in_vld.
    repeat (200) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("junk_pre_pulses", pre_cnt, 0);
    check("junk_out_vld_cnt", vld_cnt, 0);
    check("junk_bank", int'(frequency_bank), 4);
    $display("junk: pre=%0d vld=%0d", pre_cnt, vld_cnt);

    run_frame("nominal", 0, 0, 5'b10011);
    send_junk(100);
    run_frame("stretch33", 1, 0, 5'b11001);
    send_junk(100);

    // Six inverted samples: every bank tops out at 74.
    send_junk(30);
    p0 = pre_cnt;
    send_preamble(0, 6);
    send_junk(20);
    check("err6_pre_pulses", pre_cnt - p0, 0);
    $display("err6: pre=%0d", pre_cnt - p0);

    run_frame("err4", 0, 4, 5'b10101);
    send_junk(100);

    // Back-to-back frames.
    p0 = post_cnt;
    run_frame("b2b_a", 0, 0, 5'b11111);
    send_junk(200);
    run_frame("b2b_b", 0, 0, 5'b10001);
    check("b2b_post_pulses", post_cnt - p0, 2);

    // Reset asserted while forwarding payload.
    send_junk(30);
    p0 = pre_cnt;
    send_preamble(0, 0);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    check("midrst_pre_seen", pre_cnt - p0, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_vld", int'(out_vld), 0);
    check("midrst_bank", int'(frequency_bank), 4);
    model_reset();
    zrun_obs = 0;
    fwd_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_vld_next", int'(out_vld), 0);
    check("midrst_out_dat_next", int'(out_dat), 0);
    check("midrst_pre_next", int'(preamble_detected), 0);
    check("midrst_post_next", int'(postamble_detected), 0);
    check("midrst_bank_next", int'(frequency_bank), 4);
    rst = 1'b0;
    $display("midrst: bank=%0d", frequency_bank);
    run_frame("after_rst", 0, 0, 5'b11011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/preamble_detector.md
Name: preamble_detector

Overview:
- Front-end framer for the RFID reader's backscatter receive path.
- Correlates a 1-bit sample stream against BANKS time-scaled copies of a fixed preamble template.
- On detection, reports the best-matching frequency bank, then forwards subsequent samples as payload until a run of zeros (postamble) ends the frame.
- Sits between the slicer/sampler and the symbol decoder.

Parameters:
- LENGTH, 80: correlation window and template length in samples.
- BANKS, 9: number of frequency-offset banks (odd intended); centre bank C=(BANKS-1)/2 is nominal rate.
- HI_THRESHOLD, 75: minimum best-bank match count (0..LENGTH) that declares a preamble.
- LO_THRESHOLD, 70: re-arm threshold; searching resumes only once best score < LO_THRESHOLD.
- SCALING_BITS, 5: bank scale resolution; bank b scale = (2^SCALING_BITS + b - C) / 2^SCALING_BITS.
- PREAMBLE, 80'b1111111111000011110000000011111000000000000011111111 (zero-extended to LENGTH): nominal template; bit LENGTH-1 is transmitted first.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_dat  in  1  input sample.
- in_vld  in  1  in_dat valid this cycle; no backpressure.
- out_dat  out  1  forwarded payload sample.
- out_vld  out  1  out_dat valid (one-cycle strobe per sample).
- frequency_bank  out  $clog2(BANKS)  bank index of last detection.
- preamble_detected  out  1  one-cycle pulse on detection.
- postamble_detected  out  1  one-cycle pulse on end-of-frame.

Behaviour:
- Reset values:
  - Window all 0; state SEARCH; zero-run counter 0.
  - out_dat=0, out_vld=0, preamble_detected=0, postamble_detected=0.
  - frequency_bank=C.
- Window W[LENGTH-1:0]:
  - On each in_vld, W shifts {W[LENGTH-2:0], in_dat}; W[0] is the newest sample.
  - Nothing changes when in_vld=0.
- Template for bank b, position i (i=0 newest):
  - j = floor(i*2^SCALING_BITS / (2^SCALING_BITS + b - C)).
  - T_b[i] = PREAMBLE[j] if j < LENGTH, else 0.
  - All templates are elaboration-time constants.
- Score_b = count of i where next-window bit equals T_b[i] (range 0..LENGTH), computed on the window including the current in_dat.
- Best bank = max score; on a tie, the lowest index wins.
- All outputs are registered. Output pulses appear the clock after the accepted sample; out_vld, preamble_detected and postamble_detected are otherwise 0.
- SEARCH state, on in_vld:
  - If best score >= HI_THRESHOLD: pulse preamble_detected, latch frequency_bank=best bank, clear zero-run counter, go to DATA.
  - The detecting sample is not forwarded.
- DATA state, on in_vld:
  - out_dat<=in_dat, out_vld<=1.
  - Zero-run counter: +1 on a 0 sample, cleared on a 1 sample.
  - When the counter reaches LENGTH/2, pulse postamble_detected in the same cycle as that sample's out_vld, then go to REARM.
  - Scores are ignored in DATA.
- REARM state, on in_vld: if best score < LO_THRESHOLD go to SEARCH, else stay. No outputs.
- frequency_bank holds its value until the next detection.
- Reset mid-frame: immediate return to reset state; the partial frame is discarded.

Optional Feature:
- Macro: PREAMBLE_DETECTOR_SCORE_EN.
- Defined: extra output port best_score [$clog2(LENGTH+1)-1:0], registered. It carries the best score of the last accepted sample (reset 0) and is updated on every in_vld in all states.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- Reset, then 200 random samples with in_vld toggling randomly -> no preamble_detected, out_vld stays 0, frequency_bank=4.
- Junk, then PREAMBLE at nominal rate, 5 random data bits, 41 zeros, with random in_vld gaps:
  - preamble_detected one clock after the last preamble bit; frequency_bank=4.
  - First 5 out_dat values equal the data bits in order.
  - postamble_detected coincides with the 40th consecutive forwarded zero.
- Preamble with each symbol stretched by factor 33/32 -> detection with frequency_bank=5; data forwarded correctly.
- Preamble with 4 bit errors (score 76) -> detected. With 6 errors (score 74) -> not detected.
- Two frames back-to-back, separated by 200 junk samples -> two detect/postamble pulse pairs. REARM→SEARCH occurs only after best score drops below 70.
- Assert rst during the DATA phase -> all outputs 0 next cycle; a later full frame is detected normally.
